// File: rtl/cpu_bus_pkg.sv
// Shared types for the core's external memory bus: arbiter states, grant
// identifiers and the read data returned when the slave never answers.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_WAIT = 3'd2,
    D_ADDR = 3'd3,
    D_WAIT = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  localparam logic [31:0] BUS_TIMEOUT_DATA = 32'hDEADBEEF;
  localparam int          WAIT_CNT_W       = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: req[0] is fetch, req[1] is data. On a tie
// the port that did not win last time gets the grant.
module rr_pick2
  import cpu_bus_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last_grant,
  output logic       grant_valid,
  output grant_t     grant
);

  always_comb begin
    grant_valid = |req;
    grant       = GRANT_INST;
    case (req)
      2'b01:   grant = GRANT_INST;
      2'b10:   grant = GRANT_DATA;
      2'b11:   grant = (last_grant == GRANT_INST) ? GRANT_DATA : GRANT_INST;
      default: grant = GRANT_INST;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-outstanding memory bus between the fetch and data ports.
// Handshake: a port holds req until its one-cycle valid; bus address phase is
// bus_req held until bus_ack; reads then wait for bus_rvalid or a timeout.
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  output logic              i_stall,
  input  logic              d_req,
  input  logic [3:0]        d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              bus_req,
  output logic [3:0]        bus_wen,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT_C  = WAIT_CNT_W'(WAIT_LIMIT);
  localparam logic [DATA_W-1:0]     TIMEOUT_RDATA = DATA_W'(BUS_TIMEOUT_DATA);

  arb_state_t            state;
  grant_t                last_grant;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic   pick_valid;
  grant_t pick;
  logic   serving_inst;
  logic   grant_ok;

  rr_pick2 u_pick (
    .req         ({d_req, i_req}),
    .last_grant  (last_grant),
    .grant_valid (pick_valid),
    .grant       (pick)
  );

  assign i_stall = i_req && !i_valid;
  assign d_stall = d_req && !d_valid;

  assign serving_inst = (state == I_ADDR) || (state == I_WAIT);
  // The completing port still holds req during its valid cycle, so grants
  // wait one cycle after any completion.
  assign grant_ok = pick_valid && !i_valid && !d_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_INST;
      wait_cnt   <= '0;
      i_rdata    <= '0;
      i_valid    <= 1'b0;
      d_rdata    <= '0;
      d_valid    <= 1'b0;
      bus_req    <= 1'b0;
      bus_wen    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_err    <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            last_grant <= pick;
            bus_req    <= 1'b1;
            if (pick == GRANT_DATA) begin
              state     <= D_ADDR;
              bus_addr  <= d_addr;
              bus_wen   <= d_wen;
              bus_wdata <= d_wdata;
            end else begin
              state     <= I_ADDR;
              bus_addr  <= i_addr;
              bus_wen   <= '0;
              bus_wdata <= '0;
            end
          end
        end
        I_ADDR, D_ADDR: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (bus_wen != 4'b0000) begin
              d_valid <= 1'b1;
              state   <= IDLE;
            end else if (bus_rvalid) begin
              state <= IDLE;
              if (serving_inst) begin
                i_rdata <= bus_rdata;
                i_valid <= 1'b1;
              end else begin
                d_rdata <= bus_rdata;
                d_valid <= 1'b1;
              end
            end else begin
              state <= serving_inst ? I_WAIT : D_WAIT;
            end
          end
        end
        I_WAIT, D_WAIT: begin
          if (bus_rvalid || (wait_cnt == WAIT_LIMIT_C)) begin
            state    <= IDLE;
            wait_cnt <= '0;
            bus_err  <= !bus_rvalid;
            if (serving_inst) begin
              i_rdata <= bus_rvalid ? bus_rdata : TIMEOUT_RDATA;
              i_valid <= 1'b1;
            end else begin
              d_rdata <= bus_rvalid ? bus_rdata : TIMEOUT_RDATA;
              d_valid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus_req  <= 1'b0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a hand-driven bus slave, cycle-exact
// expectations and an expected read-data queue.
module tb_mem_bus_arbiter;
  import cpu_bus_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;
  logic              i_stall;
  logic              d_req;
  logic [3:0]        d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;
  logic              bus_req;
  logic [3:0]        bus_wen;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  mem_bus_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .WAIT_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_valid    (i_valid),
    .i_stall    (i_stall),
    .d_req      (d_req),
    .d_wen      (d_wen),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .d_stall    (d_stall),
    .bus_req    (bus_req),
    .bus_wen    (bus_wen),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_read(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %h want <nothing queued>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      check(tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_i_valid"}, 32'(i_valid), 32'd0);
    check({tag, "_d_valid"}, 32'(d_valid), 32'd0);
    check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    check({tag, "_i_rdata"}, i_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
    check({tag, "_bus_addr"}, bus_addr, 32'd0);
    check({tag, "_bus_wen"}, 32'(bus_wen), 32'd0);
    check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  // slave: current cycle shows bus_req; ack now, return data one cycle later
  task automatic slave_read(input logic [31:0] data);
    bus_ack = 1'b1;
    tick();
    bus_ack    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = data;
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
  endtask

  initial begin
    rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_wen = '0; d_addr = '0;
    d_wdata = '0; bus_ack = 0; bus_rvalid = 0; bus_rdata = '0;
    do_reset();
    check_idle_outputs("reset");

    // fetch only, minimum latency
    i_req = 1'b1; i_addr = 32'h100;
    exp_q.push_back(32'h12345678);
    #1;
    check("fetch_stall", 32'(i_stall), 32'd1);
    tick();
    check("fetch_bus_req", 32'(bus_req), 32'd1);
    check("fetch_bus_addr", bus_addr, 32'h100);
    check("fetch_bus_wen", 32'(bus_wen), 32'd0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("fetch_wait_req", 32'(bus_req), 32'd0);
    check("fetch_no_valid", 32'(i_valid), 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    tick();
    bus_rvalid = 1'b0;
    check("fetch_valid", 32'(i_valid), 32'd1);
    check_read("fetch_rdata", i_rdata);
    check("fetch_stall_done", 32'(i_stall), 32'd0);
    i_req = 1'b0;
    tick();
    check("fetch_valid_pulse", 32'(i_valid), 32'd0);
    check("fetch_no_regrant", 32'(bus_req), 32'd0);

    // tie after reset: data first, then fetch
    do_reset();
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_addr = 32'h400; d_wen = 4'b0000;
    exp_q.push_back(32'h44440000);
    tick();
    check("tie1_grant_addr", bus_addr, 32'h400);
    check("tie1_grant_wen", 32'(bus_wen), 32'd0);
    slave_read(32'h44440000);
    check("tie1_d_valid", 32'(d_valid), 32'd1);
    check("tie1_i_valid", 32'(i_valid), 32'd0);
    check_read("tie1_d_rdata", d_rdata);
    d_req = 1'b0;
    tick();
    check("tie1_gap_req", 32'(bus_req), 32'd0);
    check("tie1_i_stall", 32'(i_stall), 32'd1);
    exp_q.push_back(32'h33330000);
    tick();
    check("tie1_fetch_req", 32'(bus_req), 32'd1);
    check("tie1_fetch_addr", bus_addr, 32'h300);
    slave_read(32'h33330000);
    check("tie1_fetch_valid", 32'(i_valid), 32'd1);
    check_read("tie1_i_rdata", i_rdata);
    i_req = 1'b0;
    tick();

    // store with ack delayed 3 cycles
    d_req = 1'b1; d_wen = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hAABBCCDD;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("store_req", 32'(bus_req), 32'd1);
      check("store_addr", bus_addr, 32'h2000);
      check("store_wen", 32'(bus_wen), 32'h3);
      check("store_wdata", bus_wdata, 32'hAABBCCDD);
      check("store_no_valid", 32'(d_valid), 32'd0);
      if (k < 3) tick();
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("store_valid", 32'(d_valid), 32'd1);
    check("store_rdata_kept", d_rdata, 32'h44440000);
    check("store_no_wait", 32'(dut.state), 32'(IDLE));
    check("store_req_drop", 32'(bus_req), 32'd0);
    d_req = 1'b0; d_wen = 4'b0000;
    tick();
    check("store_valid_pulse", 32'(d_valid), 32'd0);

    // zero-latency slave: ack and rvalid together
    d_req = 1'b1; d_addr = 32'h500;
    exp_q.push_back(32'hCAFEF00D);
    tick();
    check("zl_req", 32'(bus_req), 32'd1);
    bus_ack = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick();
    bus_ack = 1'b0; bus_rvalid = 1'b0;
    check("zl_valid", 32'(d_valid), 32'd1);
    check_read("zl_rdata", d_rdata);
    d_req = 1'b0;
    tick();

    // second tie with last grant = data: fetch wins
    i_req = 1'b1; i_addr = 32'h600;
    d_req = 1'b1; d_addr = 32'h700;
    exp_q.push_back(32'h66660000);
    exp_q.push_back(32'h77770000);
    tick();
    check("tie2_grant_addr", bus_addr, 32'h600);
    slave_read(32'h66660000);
    check("tie2_i_valid", 32'(i_valid), 32'd1);
    check_read("tie2_i_rdata", i_rdata);
    i_req = 1'b0;
    tick();
    tick();
    check("tie2_data_addr", bus_addr, 32'h700);
    slave_read(32'h77770000);
    check("tie2_d_valid", 32'(d_valid), 32'd1);
    check_read("tie2_d_rdata", d_rdata);
    d_req = 1'b0;
    tick();

    // timeout: WAIT_LIMIT=4 -> five cycles in wait, then error
    i_req = 1'b1; i_addr = 32'h800;
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("to_no_err", 32'(bus_err), 32'd0);
      check("to_no_valid", 32'(i_valid), 32'd0);
      tick();
    end
    check("to_err", 32'(bus_err), 32'd1);
    check("to_valid", 32'(i_valid), 32'd1);
    check("to_rdata", i_rdata, 32'hDEADBEEF);
    check("to_idle", 32'(dut.state), 32'(IDLE));
    i_req = 1'b0;
    tick();
    check("to_err_pulse", 32'(bus_err), 32'd0);
    i_req = 1'b1; i_addr = 32'h900;
    exp_q.push_back(32'h900D900D);
    tick();
    check("after_to_addr", bus_addr, 32'h900);
    slave_read(32'h900D900D);
    check("after_to_valid", 32'(i_valid), 32'd1);
    check_read("after_to_rdata", i_rdata);
    i_req = 1'b0;
    tick();

    // reset in the middle of a data wait
    d_req = 1'b1; d_addr = 32'hA00;
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("rstw_in_wait", 32'(dut.state), 32'(D_WAIT));
    rst = 1'b1;
    tick();
    rst = 1'b0; d_req = 1'b0;
    check_idle_outputs("rstw");
    bus_rvalid = 1'b1; bus_rdata = 32'h0BAD0BAD;
    tick();
    bus_rvalid = 1'b0;
    check("rstw_late_d_valid", 32'(d_valid), 32'd0);
    check("rstw_late_i_valid", 32'(i_valid), 32'd0);
    check("rstw_late_rdata", d_rdata, 32'd0);
    check("rstw_late_state", 32'(dut.state), 32'(IDLE));
    tick();
    check("rstw_still_quiet", 32'(d_valid), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
